// File: rtl/cva6_ptw_sv32_walker.sv
// -----------------------------------------------------------------------------
// cva6_ptw_sv32_walker
//
// Sv32 hardware page-table walker. It takes one TLB miss at a time, reads up
// to two levels of page-table entries through a single-outstanding memory
// read port, and emits either a one-cycle refill word for the Sv32 TLB or a
// one-cycle page-fault pulse.
//
// Optional feature macro: PTW_AD_CHECK_EN
//   defined   : a leaf with A=0 faults; a leaf with D=0 faults on a store miss.
//   undefined : A/D are not inspected; the PTE is installed exactly as read.
//
// Ports
//   clk_i, rst_ni        clock; asynchronous active-low reset
//   flush_i              abort the walk in progress (no refill/fault for it)
//   satp_ppn_i[21:0]     root page-table PPN
//   miss_valid_i         miss request valid
//   miss_ready_o         walker idle and able to take a miss
//   miss_vaddr_i[31:0]   faulting virtual address
//   miss_asid_i          ASID of the miss (ASID_WIDTH bits, max 9)
//   miss_store_i         miss originates from a store
//   mem_req_o            PTE read request
//   mem_addr_o[33:0]     physical PTE address
//   mem_gnt_i            request accepted this cycle
//   mem_rvalid_i         PTE data valid
//   mem_rdata_i[31:0]    PTE
//   update_o[62:0]       refill: [62] valid, [61] is_4M, [60:51] vpn1,
//                        [50:41] vpn0, [40:32] asid, [31:0] PTE
//   walk_error_o         one-cycle page-fault pulse
//   walk_error_vaddr_o   vaddr of the most recent faulting walk
//   busy_o               walker not idle
// -----------------------------------------------------------------------------
module cva6_ptw_sv32_walker #(
    parameter int unsigned ASID_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [21:0]           satp_ppn_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [31:0]           miss_vaddr_i,
    input  logic [ASID_WIDTH-1:0] miss_asid_i,
    input  logic                  miss_store_i,
    output logic                  mem_req_o,
    output logic [33:0]           mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [62:0]           update_o,
    output logic                  walk_error_o,
    output logic [31:0]           walk_error_vaddr_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_L1_REQ  = 3'd1,
        S_L1_WAIT = 3'd2,
        S_L0_REQ  = 3'd3,
        S_L0_WAIT = 3'd4,
        S_DRAIN   = 3'd5
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Miss context captured at acceptance
    logic [31:0]           r_vaddr;
    logic [ASID_WIDTH-1:0] r_asid;
    logic                  r_store;
    logic [21:0]           r_satp_ppn;
    // Next-level table PPN from a non-leaf L1 PTE
    logic [21:0]           r_ppn;

    // Registered output pulses and held payloads
    logic                  r_upd_valid;
    logic [61:0]           r_upd_data;
    logic                  r_err;
    logic [31:0]           r_err_vaddr;

    // FSM decisions
    logic                  w_accept;
    logic                  w_latch_ppn;
    logic                  w_refill;
    logic                  w_refill_4m;
    logic                  w_fault;
    logic                  w_miss_ready;
    logic                  w_mem_req;
    logic [33:0]           w_mem_addr;

    // PTE decode of the incoming read data
    logic                  w_pte_v;
    logic                  w_pte_r;
    logic                  w_pte_w;
    logic                  w_pte_x;
    logic                  w_pte_invalid;
    logic                  w_pte_leaf;
    logic                  w_pte_misaligned;
    logic                  w_ad_fault;
    logic [8:0]            w_asid_ext;

    assign w_pte_v          = mem_rdata_i[0];
    assign w_pte_r          = mem_rdata_i[1];
    assign w_pte_w          = mem_rdata_i[2];
    assign w_pte_x          = mem_rdata_i[3];
    // W without R is a reserved encoding and is treated like an invalid PTE
    assign w_pte_invalid    = !w_pte_v || (!w_pte_r && w_pte_w);
    assign w_pte_leaf       = w_pte_r || w_pte_x;
    // A 4 MiB superpage must have PPN[0] (PTE bits 19:10) equal to zero
    assign w_pte_misaligned = |mem_rdata_i[19:10];
    assign w_asid_ext       = 9'(r_asid);

`ifdef PTW_AD_CHECK_EN
    logic w_pte_a;
    logic w_pte_d;

    assign w_pte_a    = mem_rdata_i[6];
    assign w_pte_d    = mem_rdata_i[7];
    // Software-managed A/D: a leaf that would need an A/D update faults
    assign w_ad_fault = w_pte_leaf && (!w_pte_a || (r_store && !w_pte_d));
`else
    logic w_unused_store;

    // The store bit only matters for the D check, which is compiled out here
    assign w_unused_store = r_store;
    assign w_ad_fault     = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_miss_ready = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_addr   = '0;
        w_accept     = 1'b0;
        w_latch_ppn  = 1'b0;
        w_refill     = 1'b0;
        w_refill_4m  = 1'b0;
        w_fault      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_miss_ready = !flush_i;
                if (miss_valid_i && !flush_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_L1_REQ;
                end
            end

            S_L1_REQ: begin
                w_mem_req  = 1'b1;
                w_mem_addr = {r_satp_ppn, r_vaddr[31:22], 2'b00};
                if (flush_i) begin
                    // A grant in the flush cycle leaves a read in flight
                    w_state_next = mem_gnt_i ? S_DRAIN : S_IDLE;
                end else if (mem_gnt_i) begin
                    w_state_next = S_L1_WAIT;
                end
            end

            S_L1_WAIT: begin
                if (mem_rvalid_i) begin
                    w_state_next = S_IDLE;
                    if (!flush_i) begin
                        if (w_pte_invalid) begin
                            w_fault = 1'b1;
                        end else if (w_pte_leaf) begin
                            if (w_pte_misaligned || w_ad_fault) begin
                                w_fault = 1'b1;
                            end else begin
                                w_refill    = 1'b1;
                                w_refill_4m = 1'b1;
                            end
                        end else begin
                            w_latch_ppn  = 1'b1;
                            w_state_next = S_L0_REQ;
                        end
                    end
                end else if (flush_i) begin
                    w_state_next = S_DRAIN;
                end
            end

            S_L0_REQ: begin
                w_mem_req  = 1'b1;
                w_mem_addr = {r_ppn, r_vaddr[21:12], 2'b00};
                if (flush_i) begin
                    w_state_next = mem_gnt_i ? S_DRAIN : S_IDLE;
                end else if (mem_gnt_i) begin
                    w_state_next = S_L0_WAIT;
                end
            end

            S_L0_WAIT: begin
                if (mem_rvalid_i) begin
                    w_state_next = S_IDLE;
                    if (!flush_i) begin
                        // Sv32 has no level below L0, so a pointer here faults
                        if (w_pte_invalid || !w_pte_leaf || w_ad_fault) begin
                            w_fault = 1'b1;
                        end else begin
                            w_refill = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    w_state_next = S_DRAIN;
                end
            end

            S_DRAIN: begin
                // Swallow the response of the aborted read before accepting work
                if (mem_rvalid_i) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Miss context and table pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vaddr    <= '0;
            r_asid     <= '0;
            r_store    <= 1'b0;
            r_satp_ppn <= '0;
            r_ppn      <= '0;
        end else begin
            if (w_accept) begin
                r_vaddr    <= miss_vaddr_i;
                r_asid     <= miss_asid_i;
                r_store    <= miss_store_i;
                // Captured so the L1 address stays stable across a grant stall
                r_satp_ppn <= satp_ppn_i;
            end
            if (w_latch_ppn) begin
                r_ppn <= mem_rdata_i[31:10];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Refill and fault outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_upd_valid <= 1'b0;
            r_upd_data  <= '0;
            r_err       <= 1'b0;
            r_err_vaddr <= '0;
        end else begin
            r_upd_valid <= w_refill;
            if (w_refill) begin
                r_upd_data <= {w_refill_4m, r_vaddr[31:22], r_vaddr[21:12],
                               w_asid_ext, mem_rdata_i};
            end
            r_err <= w_fault;
            if (w_fault) begin
                r_err_vaddr <= r_vaddr;
            end
        end
    end

    assign miss_ready_o       = w_miss_ready;
    assign mem_req_o          = w_mem_req;
    assign mem_addr_o         = w_mem_addr;
    assign update_o           = {r_upd_valid, r_upd_data};
    assign walk_error_o       = r_err;
    assign walk_error_vaddr_o = r_err_vaddr;
    assign busy_o             = (r_state != S_IDLE);

endmodule
